// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation ADC controller.
package sar_pkg;
  localparam int N_BITS_DEF        = 8;
  localparam int SAMPLE_CYCLES_DEF = 2;
  localparam int CNT_W             = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_e;
endpackage

// File: rtl/sar_ctrl_if.sv
// Control/data bundle between a conversion requester and the SAR controller.
interface sar_ctrl_if
  import sar_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
);
  logic              start;
  logic              comp_in;
  logic              sample_en;
  logic [N_BITS-1:0] dac_code;
  logic [N_BITS-1:0] result;
  logic              valid;
  logic              busy;

  modport master (
    output start, comp_in,
    input  sample_en, dac_code, result, valid, busy
  );

  modport slave (
    input  start, comp_in,
    output sample_en, dac_code, result, valid, busy
  );
endinterface

// File: rtl/sar_register.sv
// Bit pointer and trial code: one comparator decision per step, MSB first.
module sar_register
  import sar_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              comp,
  output logic [N_BITS-1:0] code,
  output logic              last
);
  localparam int PW = $clog2(N_BITS);

  logic [PW-1:0] ptr;

  // The last decision clears the code so the DAC idles at zero; the caller
  // captures the final result from the pre-clear code plus this decision.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      code <= '0;
      ptr  <= '0;
    end else if (load) begin
      code             <= '0;
      code[N_BITS-1]   <= 1'b1;
      ptr              <= PW'(N_BITS - 1);
    end else if (step) begin
      if (ptr == '0) begin
        code <= '0;
      end else begin
        code[ptr]        <= comp;
        code[ptr - 1'b1] <= 1'b1;
        ptr              <= ptr - 1'b1;
      end
    end
  end

  assign last = (ptr == '0);
endmodule

// File: rtl/sar_ctrl.sv
// SAR ADC sequencer: track window, N_BITS binary-search decisions, result strobe.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS        = N_BITS_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
) (
  input logic       clk_in,
  input logic       rst,
  sar_ctrl_if.slave bus
);
  sar_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              sample_en_q;
  logic [N_BITS-1:0] result_q;
  logic              valid_q;
  logic              busy_q;
  logic [N_BITS-1:0] code;
  logic              last;
  logic              load;
  logic              step;
  logic              sample_end;

  assign sample_end = (cnt == CNT_W'(SAMPLE_CYCLES - 1));
  assign load       = (state == SAMPLE) && sample_end;
  assign step       = (state == CONVERT);

  sar_register #(.N_BITS(N_BITS)) u_reg (
    .clk_in (clk_in),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .comp   (bus.comp_in),
    .code   (code),
    .last   (last)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sample_en_q <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.start) begin
            state       <= SAMPLE;
            sample_en_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SAMPLE: begin
          if (sample_end) begin
            state       <= CONVERT;
            sample_en_q <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONVERT: begin
          // Bit 0 decision lands straight in the result; no further trial bit.
          if (last) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            result_q <= {code[N_BITS-1:1], bus.comp_in};
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sample_en = sample_en_q;
  assign bus.dac_code  = code;
  assign bus.result    = result_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an ideal comparator model (vin >= dac_code).
module tb_sar_ctrl;
  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] vin    = 8'h00;
  logic       use_rand = 1'b0;
  logic       rand_bit = 1'b0;
  int         n_pass = 0;
  int         n_chk  = 0;

  sar_ctrl_if #(.N_BITS(8)) bus ();

  sar_ctrl #(.N_BITS(8), .SAMPLE_CYCLES(2)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  assign bus.comp_in = use_rand ? rand_bit : (vin >= bus.dac_code);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One conversion from a start pulse; checks cycles t0+1 .. t0+13.
  task automatic run_conv(input logic [7:0] v, input logic [7:0] exp_res,
                          input bit chk_seq, input int restart_at);
    logic [7:0] seq [8];
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("sample_en[%0h] t0+%0d", v, k), 32'(bus.sample_en), 32'(k == 1 || k == 2));
      chk($sformatf("busy[%0h] t0+%0d", v, k), 32'(bus.busy), 32'(k <= 10));
      chk($sformatf("valid[%0h] t0+%0d", v, k), 32'(bus.valid), 32'(k == 11));
      if (k <= 2 || k >= 11)
        chk($sformatf("dac_idle[%0h] t0+%0d", v, k), 32'(bus.dac_code), 32'h0);
      else if (chk_seq)
        chk($sformatf("dac_seq t0+%0d", k), 32'(bus.dac_code), 32'(seq[k-3]));
      if (k == 11 || k == 13)
        chk($sformatf("result[%0h] t0+%0d", v, k), 32'(bus.result), 32'(exp_res));
      bus.start = (k == restart_at);
      tick();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int prev;
    int strobes;
    logic saw_valid;
    bus.start = 1'b1;

    // Reset has priority over a simultaneous start.
    tick();
    tick();
    chk("rst sample_en", 32'(bus.sample_en), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    chk("rst valid", 32'(bus.valid), 32'h0);
    chk("rst dac_code", 32'(bus.dac_code), 32'h0);
    chk("rst result", 32'(bus.result), 32'h0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();

    run_conv(8'hA5, 8'hA5, 1'b1, 0);
    run_conv(8'h00, 8'h00, 1'b0, 0);
    run_conv(8'hFF, 8'hFF, 1'b0, 0);
    run_conv(8'h5A, 8'h5A, 1'b0, 5);

    // Back-to-back with start held high.
    vin = 8'h3C;
    bus.start = 1'b1;
    tick();
    prev = -1;
    strobes = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.valid) begin
        chk($sformatf("b2b result #%0d", strobes), 32'(bus.result), 32'h3C);
        if (prev < 0) chk("b2b first strobe", 32'(i), 32'd11);
        else chk($sformatf("b2b period #%0d", strobes), 32'(i - prev), 32'd12);
        prev = i;
        strobes++;
      end
      tick();
    end
    chk("b2b strobe count", 32'(strobes), 32'd3);
    bus.start = 1'b0;
    repeat (16) tick();
    chk("b2b drained busy", 32'(bus.busy), 32'h0);

    // Reset mid-conversion aborts without a strobe.
    vin = 8'hC3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("pre-abort busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'h0);
    chk("abort sample_en", 32'(bus.sample_en), 32'h0);
    chk("abort dac_code", 32'(bus.dac_code), 32'h0);
    chk("abort result", 32'(bus.result), 32'h0);
    chk("abort valid", 32'(bus.valid), 32'h0);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      saw_valid |= bus.valid | bus.busy;
      tick();
    end
    chk("abort no activity", 32'(saw_valid), 32'h0);
    run_conv(8'h6E, 8'h6E, 1'b0, 0);

    // Comparator noise while idle must not disturb the held result.
    run_conv(8'h11, 8'h11, 1'b0, 0);
    use_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_bit = 1'($urandom);
      tick();
      chk($sformatf("idle result %0d", i), 32'(bus.result), 32'h11);
      chk($sformatf("idle valid %0d", i), 32'(bus.valid), 32'h0);
    end
    use_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 Parameter N_BITS, default 8, SHALL set the conversion resolution in bits; legal range 2..16.
REQ-002 Parameter SAMPLE_CYCLES, default 2, SHALL set the track/acquisition window in clk_in cycles; legal range 1..255.
REQ-003 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request one conversion; sampled only in IDLE.
REQ-006 comp_in  input  1  SHALL be the comparator decision: 1 = Vin >= DAC(dac_code), 0 = Vin < DAC(dac_code).
REQ-007 sample_en  output  1  SHALL drive the sample/hold switch: 1 = track, 0 = hold.
REQ-008 dac_code  output  N_BITS  SHALL be the trial code presented to the capacitive DAC.
REQ-009 result  output  N_BITS  SHALL be the last completed conversion result.
REQ-010 valid  output  1  SHALL be a one-cycle strobe marking a new result.
REQ-011 busy  output  1  SHALL be high while a conversion is in progress (SAMPLE or CONVERT).

Function
REQ-012 The FSM SHALL have states IDLE, SAMPLE, CONVERT, DONE; all outputs registered.
REQ-013 IDLE: start=1 at edge t0 -> SAMPLE from cycle t0+1; start=0 -> stay IDLE; sample_en=0, busy=0, dac_code=0.
REQ-014 SAMPLE: sample_en=1, busy=1, dac_code=0; an 8-bit counter SHALL hold the state for exactly SAMPLE_CYCLES cycles, then -> CONVERT.
REQ-015 On entry to CONVERT, dac_code SHALL be the mid-scale code (MSB=1, others 0), the bit pointer SHALL be N_BITS-1, and sample_en=0.
REQ-016 Each CONVERT edge SHALL test the bit at the pointer: comp_in=0 clears it, comp_in=1 keeps it; the next-lower bit SHALL be set in the same update; the pointer SHALL decrement.
REQ-017 CONVERT SHALL last exactly N_BITS cycles; the decision on bit 0 SHALL move the FSM to DONE with no new trial bit set.
REQ-018 DONE SHALL last one cycle: result = final code, valid=1, busy=0; then -> IDLE.
REQ-019 Latency: with start sampled at edge t0, valid SHALL be high exactly in cycle t0+SAMPLE_CYCLES+N_BITS+1.
REQ-020 start in SAMPLE, CONVERT or DONE SHALL be ignored; it is not queued.
REQ-021 With start held high continuously, conversions SHALL run back-to-back with period SAMPLE_CYCLES+N_BITS+2 cycles.
REQ-022 result SHALL hold its value between valid strobes; comp_in SHALL be ignored outside CONVERT.

Reset
REQ-023 rst=1 at any edge SHALL force IDLE and set sample_en=0, dac_code=0, result=0, valid=0, busy=0, and clear all counters.
REQ-024 rst asserted mid-conversion SHALL abort it with no valid strobe; rst has priority over start.

Structure
REQ-025 Package sar_pkg SHALL hold the state enumeration, the default N_BITS/SAMPLE_CYCLES constants and the sample-counter width.
REQ-026 The bit-pointer/trial-code logic SHALL be one sub-module, sar_register (inputs: load, step, comp; outputs: code, last).

Verification (N_BITS=8, SAMPLE_CYCLES=2; comparator model comp_in = (vin >= dac_code))
REQ-027 vin=0xA5, start pulse at t0 -> dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; result=0xA5; valid high in cycle t0+11 only.
REQ-028 vin=0x00 and vin=0xFF -> result=0x00 and 0xFF respectively; sample_en high in cycles t0+1..t0+2 only.
REQ-029 start held high for 40 cycles, vin=0x3C -> valid strobes 12 cycles apart, every result=0x3C.
REQ-030 start pulsed again at t0+5 during a conversion of vin=0x5A -> ignored; single valid at t0+11 with result=0x5A.
REQ-031 rst pulsed at t0+6 during a conversion -> next cycle IDLE, all outputs 0, no valid; a new start converts correctly.
REQ-032 After a completed conversion of vin=0x11, comp_in toggled randomly while in IDLE -> result stays 0x11, valid stays 0.
